// File: rtl/matmul_loader_pkg.sv
// -----------------------------------------------------------------------------
// matmul_loader_pkg
//   Shared types and helpers for the matmul loader slice.
//   - loader_state_t : loader FSM states
//   - n_elems()      : element count of an N x N matrix
//   - cnt_width()    : width of a 0..N-1 row/column counter (minimum 1 bit)
// -----------------------------------------------------------------------------
package matmul_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_X    = 3'd1,
    LOAD_Y    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } loader_state_t;

  function automatic int n_elems(input int n);
    return n * n;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_loader_if.sv
// -----------------------------------------------------------------------------
// matmul_loader_if
//   Bundles the loader's data-path connections:
//     in_valid/in_ready/in_data        word stream into the loader
//     x_wr_en/x_addr/x_din             X BRAM write port
//     y_wr_en/y_addr/y_din             Y BRAM write port
//     mm_start/mm_done                 matmul core start/done handshake
//   modport slave  : the loader's view
//   modport master : the surrounding system's view (stream source, BRAMs, core)
// -----------------------------------------------------------------------------
interface matmul_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  x_wr_en;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_din;
  logic                  y_wr_en;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] y_din;
  logic                  mm_start;
  logic                  mm_done;

  modport slave (
    input  in_valid, in_data, mm_done,
    output in_ready, x_wr_en, x_addr, x_din, y_wr_en, y_addr, y_din, mm_start
  );

  modport master (
    output in_valid, in_data, mm_done,
    input  in_ready, x_wr_en, x_addr, x_din, y_wr_en, y_addr, y_din, mm_start
  );
endinterface

// File: rtl/matmul_loader_addr_gen.sv
// -----------------------------------------------------------------------------
// matmul_addr_gen
//   Element position counter shared by the X and Y load phases.
//   The inner counter advances on every accepted word and wraps at N-1, carrying
//   into the outer counter.
//   Ports:
//     clock, reset_n  clock / async active-low reset
//     clear           synchronous return of both counters to 0
//     advance         step to the next element
//     transpose       0: addr = outer*N + inner (row-major stream)
//                     1: addr = inner*N + outer (column-major stream stored
//                        row-major: the fast index selects the BRAM row)
//     addr            write address of the current element
//     last            current element is the final one of the matrix
// -----------------------------------------------------------------------------
module matmul_addr_gen
  import matmul_loader_pkg::*;
#(
  parameter int MATRIX_SIZE = 32,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic                  transpose,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int                    CW    = cnt_width(MATRIX_SIZE);
  localparam logic [CW-1:0]         MAX_C = CW'(MATRIX_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] N_A   = ADDR_WIDTH'(MATRIX_SIZE);

  logic [CW-1:0] inner_r;
  logic [CW-1:0] outer_r;

  // Inner/outer element counters with wrap and carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inner_r <= {CW{1'b0}};
      outer_r <= {CW{1'b0}};
    end else if (clear) begin
      inner_r <= {CW{1'b0}};
      outer_r <= {CW{1'b0}};
    end else if (advance) begin
      if (inner_r == MAX_C) begin
        inner_r <= {CW{1'b0}};
        outer_r <= (outer_r == MAX_C) ? {CW{1'b0}} : outer_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        inner_r <= inner_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign last = (inner_r == MAX_C) && (outer_r == MAX_C);
  assign addr = transpose ? (ADDR_WIDTH'(inner_r) * N_A + ADDR_WIDTH'(outer_r))
                          : (ADDR_WIDTH'(outer_r) * N_A + ADDR_WIDTH'(inner_r));

endmodule

// File: rtl/matmul_loader.sv
// -----------------------------------------------------------------------------
// matmul_loader
//   Upstream feeder for the matmul core. Takes N*N words of X then N*N words of
//   Y from a valid/ready stream, writes them to the X/Y BRAMs (one cycle after
//   acceptance), pulses mm_start, waits for a rising edge of mm_done and then
//   pulses job_done.
//   Ports:
//     clock, reset_n  clock / async active-low reset
//     load            start a job (only honoured in IDLE)
//     busy            high in every state except IDLE
//     job_done        one-cycle pulse when the core finishes
//     bus (slave)     stream, X/Y BRAM write ports, mm_start/mm_done
//   Build option:
//     MATMUL_LOADER_TRANSPOSE_Y_EN  Y stream is column-major and is scattered
//                                   into row-major Y BRAM addresses.
// -----------------------------------------------------------------------------
module matmul_loader
  import matmul_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MATRIX_SIZE = 32,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  output logic            busy,
  output logic            job_done,
  matmul_loader_if.slave  bus
);

  loader_state_t         state_r;
  logic                  mm_done_q_r;
  logic                  busy_r;
  logic                  job_done_r;
  logic                  mm_start_r;
  logic                  x_wr_en_r;
  logic [ADDR_WIDTH-1:0] x_addr_r;
  logic [DATA_WIDTH-1:0] x_din_r;
  logic                  y_wr_en_r;
  logic [ADDR_WIDTH-1:0] y_addr_r;
  logic [DATA_WIDTH-1:0] y_din_r;

  logic                  in_ready_s;
  logic                  accept_s;
  logic                  clear_s;
  logic                  transpose_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  last_s;

  assign in_ready_s = (state_r == LOAD_X) || (state_r == LOAD_Y);
  assign accept_s   = bus.in_valid & in_ready_s;
  // Counters sit at 0 while idle, so every job starts at address 0.
  assign clear_s    = (state_r == IDLE);

`ifdef MATMUL_LOADER_TRANSPOSE_Y_EN
  assign transpose_s = (state_r == LOAD_Y);
`else
  assign transpose_s = 1'b0;
`endif

  matmul_addr_gen #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear_s),
    .advance   (accept_s),
    .transpose (transpose_s),
    .addr      (addr_s),
    .last      (last_s)
  );

  // Loader FSM with registered BRAM writes, start/done pulses and busy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      mm_done_q_r <= 1'b0;
      busy_r      <= 1'b0;
      job_done_r  <= 1'b0;
      mm_start_r  <= 1'b0;
      x_wr_en_r   <= 1'b0;
      x_addr_r    <= {ADDR_WIDTH{1'b0}};
      x_din_r     <= {DATA_WIDTH{1'b0}};
      y_wr_en_r   <= 1'b0;
      y_addr_r    <= {ADDR_WIDTH{1'b0}};
      y_din_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      // Pulse outputs default low; mm_done is tracked every cycle for edge detect.
      mm_done_q_r <= bus.mm_done;
      job_done_r  <= 1'b0;
      mm_start_r  <= 1'b0;
      x_wr_en_r   <= 1'b0;
      y_wr_en_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            state_r <= LOAD_X;
            busy_r  <= 1'b1;
          end
        end
        LOAD_X: begin
          if (accept_s) begin
            x_wr_en_r <= 1'b1;
            x_addr_r  <= addr_s;
            x_din_r   <= bus.in_data;
            if (last_s) begin
              state_r <= LOAD_Y;
            end
          end
        end
        LOAD_Y: begin
          if (accept_s) begin
            y_wr_en_r <= 1'b1;
            y_addr_r  <= addr_s;
            y_din_r   <= bus.in_data;
            if (last_s) begin
              state_r <= START;
            end
          end
        end
        START: begin
          mm_start_r <= 1'b1;
          state_r    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Edge, not level: a done left high by the previous job is ignored.
          if (bus.mm_done && !mm_done_q_r) begin
            job_done_r <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.x_wr_en  = x_wr_en_r;
  assign bus.x_addr   = x_addr_r;
  assign bus.x_din    = x_din_r;
  assign bus.y_wr_en  = y_wr_en_r;
  assign bus.y_addr   = y_addr_r;
  assign bus.y_din    = y_din_r;
  assign bus.mm_start = mm_start_r;
  assign busy         = busy_r;
  assign job_done     = job_done_r;

endmodule

// File: tb/tb_matmul_loader.sv
// -----------------------------------------------------------------------------
// tb_matmul_loader
//   Scoreboard bench for matmul_loader with N=4. Stimulus pushes the expected
//   BRAM write for every accepted word; a negedge monitor pops and compares
//   whenever a write enable is seen.
// -----------------------------------------------------------------------------
module tb_matmul_loader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 4;

  typedef struct packed {
    logic          is_y;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load = 1'b0;
  logic busy;
  logic job_done;

  matmul_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matmul_loader #(
    .DATA_WIDTH  (DW),
    .MATRIX_SIZE (N),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .busy     (busy),
    .job_done (job_done),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [DW-1:0] xmem [N*N];
  logic [DW-1:0] ymem [N*N];
  int cycle = 0;
  int x15_cyc = -1;
  int y0_cyc = -1;
  int starts = 0;
  int dones = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected BRAM address for stream word k of a job (0..2*N*N-1).
  function automatic int exp_addr(input int k);
    int j;
    if (k < N*N) return k;
    j = k - N*N;
`ifdef MATMUL_LOADER_TRANSPOSE_Y_EN
    return (j % N) * N + (j / N);
`else
    return j;
`endif
  endfunction

  // Monitor: scoreboard pops, pulse counting, bench copies of BRAM contents.
  always @(negedge clock) begin
    if (reset_n) begin
      cycle++;
      if (bus.mm_start) starts++;
      if (job_done) dones++;
      if (bus.x_wr_en || bus.y_wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write x=%0b y=%0b queue=0 required=nonempty", bus.x_wr_en, bus.y_wr_en);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("write_port_y", {63'd0, bus.y_wr_en}, {63'd0, e.is_y});
          check_eq("write_one_port", {63'd0, bus.x_wr_en & bus.y_wr_en}, 64'd0);
          if (bus.x_wr_en) begin
            check_eq("x_addr", {60'd0, bus.x_addr}, {60'd0, e.addr});
            check_eq("x_din", {32'd0, bus.x_din}, {32'd0, e.data});
            xmem[bus.x_addr] = bus.x_din;
            if (bus.x_addr == 4'd15) x15_cyc = cycle;
          end else begin
            check_eq("y_addr", {60'd0, bus.y_addr}, {60'd0, e.addr});
            check_eq("y_din", {32'd0, bus.y_din}, {32'd0, e.data});
            ymem[bus.y_addr] = bus.y_din;
            if (bus.y_addr == 4'd0) y0_cyc = cycle;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input int k, input logic [DW-1:0] d, input logic ld);
    int t;
    exp_t e;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    load         = ld;
    @(negedge clock);
    while (!bus.in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check_eq("in_ready_seen", {63'd0, bus.in_ready}, 64'd1);
    if (bus.in_ready) begin
      e.is_y = (k >= N*N);
      e.addr = AW'(exp_addr(k));
      e.data = d;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    load         = 1'b0;
  endtask

  task automatic start_job();
    load = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    check_eq("busy_after_load", {63'd0, busy}, 64'd1);
  endtask

  // Streams words [from, to) with value base+k, optional gaps and a load pulse at word ld_at.
  task automatic stream(input int from, input int to, input int base, input bit gaps, input int ld_at);
    for (int k = from; k < to; k++) begin
      if (gaps && ($urandom_range(1) == 1)) begin
        @(posedge clock);
        #1;
      end
      send_word(k, DW'(base + k), (k == ld_at));
    end
  endtask

  // Core model: wait for mm_start, keep stale done 2 cycles, drop, raise 5 cycles later.
  task automatic complete_job(input bit ld_in_wait);
    int t;
    t = 0;
    while (!bus.mm_start && t < 100) begin
      @(negedge clock);
      t++;
    end
    check_eq("mm_start_seen", {63'd0, bus.mm_start}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_eq("stale_done_ignored", {63'd0, job_done}, 64'd0);
    end
    @(posedge clock);
    #1;
    bus.mm_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ld_in_wait && i == 2) load = 1'b1;
      @(negedge clock);
      check_eq("no_early_done", {63'd0, job_done}, 64'd0);
      @(posedge clock);
      #1;
      load = 1'b0;
    end
    bus.mm_done = 1'b1;
    @(negedge clock);
    check_eq("done_not_before", {63'd0, job_done}, 64'd0);
    @(negedge clock);
    check_eq("done_latency", {63'd0, job_done}, 64'd1);
    check_eq("busy_cleared", {63'd0, busy}, 64'd0);
    @(negedge clock);
    check_eq("done_pulse_width", {63'd0, job_done}, 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic check_mems(input string tag);
    for (int i = 0; i < N*N; i++) begin
      check_eq({tag, "_xmem"}, {32'd0, xmem[i]}, 64'(i));
      check_eq({tag, "_ymem"}, {32'd0, ymem[exp_addr(N*N + i)]}, 64'(N*N + i));
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < N*N; i++) begin
      xmem[i] = 32'hDEAD_BEEF;
      ymem[i] = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    int s0;
    int d0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.mm_done  = 1'b0;
    clear_mems();

    // Reset state.
    #12;
    check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_outputs", {bus.x_wr_en, bus.y_wr_en, bus.mm_start, job_done, bus.x_addr, bus.y_addr}, 64'd0);
    check_eq("rst_din", {bus.x_din, bus.y_din}, 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // in_valid while idle must not produce writes.
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.in_valid = 1'b0;

    // Test 1: continuous stream, row-major (or transposed Y).
    start_job();
    stream(0, 2*N*N, 0, 1'b0, -1);
    complete_job(1'b0);
    check_eq("t1_x15_to_y0_gap", 64'(y0_cyc - x15_cyc), 64'd1);
    check_eq("t1_starts", 64'(starts), 64'd1);
    check_eq("t1_dones", 64'(dones), 64'd1);
    check_mems("t1");
`ifdef MATMUL_LOADER_TRANSPOSE_Y_EN
    check_eq("t6_y1", {32'd0, ymem[1]}, 64'd20);
    check_eq("t6_y4", {32'd0, ymem[4]}, 64'd17);
`else
    check_eq("t1_y1", {32'd0, ymem[1]}, 64'd17);
    check_eq("t1_y4", {32'd0, ymem[4]}, 64'd20);
`endif

    // Tests 2+3: random gaps, stale done held from job 1.
    clear_mems();
    start_job();
    stream(0, 2*N*N, 0, 1'b1, -1);
    complete_job(1'b0);
    check_eq("t2_starts", 64'(starts), 64'd2);
    check_mems("t2");

    // Test 4: reset after 7 X words.
    s0 = starts;
    start_job();
    stream(0, 7, 100, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    check_eq("t4_rst_outputs", {bus.x_wr_en, bus.y_wr_en, bus.mm_start, job_done, bus.in_ready, busy, bus.x_addr, bus.y_addr}, 64'd0);
    check_eq("t4_rst_din", {bus.x_din, bus.y_din}, 64'd0);
    check_eq("t4_pending_killed", 64'(sb.size()), 64'd1);
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("t4_no_start", 64'(starts), 64'(s0));
    check_eq("t4_idle", {62'd0, busy, bus.in_ready}, 64'd0);
    clear_mems();
    start_job();
    stream(0, 2*N*N, 0, 1'b0, -1);
    complete_job(1'b0);
    check_mems("t4");

    // Test 5: load during LOAD_Y and WAIT_DONE is ignored.
    s0 = starts;
    d0 = dones;
    start_job();
    stream(0, 2*N*N, 200, 1'b0, 20);
    complete_job(1'b1);
    repeat (4) @(posedge clock);
    #1;
    check_eq("t5_starts", 64'(starts - s0), 64'd1);
    check_eq("t5_dones", 64'(dones - d0), 64'd1);
    check_eq("t5_stays_idle", {62'd0, busy, bus.in_ready}, 64'd0);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
